// File: rtl/clint_pri.sv
// clint_pri: core-local interrupt controller.
// Arbitrates ECALL/EBREAK, NUM_IRQ maskable level interrupts and MRET.
// It runs the mepc/mstatus/mcause write sequence and then issues the
// redirect to ex. Direct and vectored mtvec modes are supported.
module clint_pri #(
  parameter int NUM_IRQ     = 8,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET_ST, S_MRET_JMP
  } state_e;

  state_e state_q, state_d;

  // Trap context captured when leaving IDLE
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [4:0]  code_q, code_d;
  logic        async_q, async_d;

  // Registered outputs, loaded on entry to each state
  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        data_q, data_d;
  logic               assert_q, assert_d;
  logic [31:0]        addr_q, addr_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [NUM_IRQ-1:0] pend;
  logic [3:0]         irq_idx;
  logic [4:0]         irq_code;
  logic               is_ecall, is_ebreak, is_mret;
  logic               sync_ev, irq_ev, mret_ev;
  logic [31:0]        vec_base;
  logic               vec_mode;

  assign pend      = irq_i & irq_mask_i;
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign sync_ev   = is_ecall | is_ebreak;
  assign irq_ev    = (|pend) & global_int_en_i;
  assign mret_ev   = is_mret;
  assign irq_code  = 5'd16 + 5'(irq_idx);
  assign vec_base  = csr_mtvec & ~32'h3;
  assign vec_mode  = VECTORED_EN && (csr_mtvec[1:0] == 2'b01) && async_q;

  // Lowest pending line wins: scan downward so the last hit is the lowest
  always_comb begin
    irq_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = 4'(i);
    end
  end

  // Hold ex while detecting an event and for the whole sequence
  assign hold_flag_o = (state_q != S_IDLE) | sync_ev | irq_ev | mret_ev;

  // Next state, trap capture and next output values
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    code_d   = code_q;
    async_d  = async_q;
    we_d     = 1'b0;
    waddr_d  = 32'h0;
    data_d   = 32'h0;
    assert_d = 1'b0;
    addr_d   = 32'h0;
    ack_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (sync_ev) begin
          state_d = S_MEPC;
          pc_d    = inst_addr_i;
          cause_d = is_ecall ? 32'd11 : 32'd3;
          code_d  = 5'd0;
          async_d = 1'b0;
        end else if (irq_ev) begin
          state_d = S_MEPC;
          pc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = {1'b1, 26'h0, irq_code};
          code_d  = irq_code;
          async_d = 1'b1;
        end else if (mret_ev) begin
          state_d = S_MRET_ST;
        end
      end
      S_MEPC:     state_d = S_MSTATUS;
      S_MSTATUS:  state_d = S_MCAUSE;
      S_MCAUSE:   state_d = S_ASSERT;
      S_ASSERT:   state_d = S_IDLE;
      S_MRET_ST:  state_d = S_MRET_JMP;
      S_MRET_JMP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs belong to the state being entered
    case (state_d)
      S_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = pc_d;
        if (state_q == S_IDLE && !sync_ev) ack_d = NUM_IRQ'(1) << irq_idx;
      end
      S_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        // MPIE <- MIE, MIE <- 0
        data_d  = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4],
                   1'b0, csr_mstatus[2:0]};
      end
      S_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      S_ASSERT: begin
        assert_d = 1'b1;
        addr_d   = vec_mode ? vec_base + {25'h0, code_q, 2'b00} : vec_base;
      end
      S_MRET_ST: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        // MIE <- MPIE, MPIE <- 1
        data_d  = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4],
                   csr_mstatus[7], csr_mstatus[2:0]};
      end
      S_MRET_JMP: begin
        assert_d = 1'b1;
        addr_d   = csr_mepc;
      end
      default: ;
    endcase
  end

  // State, trap context and output registers; reset aborts any sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 32'h0;
      cause_q  <= 32'h0;
      code_q   <= 5'h0;
      async_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 32'h0;
      data_q   <= 32'h0;
      assert_q <= 1'b0;
      addr_q   <= 32'h0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      code_q   <= code_d;
      async_q  <= async_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = assert_q;
  assign int_addr_o   = addr_q;
  assign irq_ack_o    = ack_q;

endmodule

// File: tb/tb_clint_pri.sv
// tb_clint_pri: directed plan cases plus randomized stimulus against a
// queue-based reference model of the write/redirect sequence.
module tb_clint_pri;
  localparam int NUM_IRQ = 8;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic               gclk = 1'b0;
  logic               grst_n;
  logic [NUM_IRQ-1:0] irq, mask;
  logic               mie;
  logic [31:0]        inst, iaddr, jaddr, mtvec, mepc, mstatus;
  logic               jflag;
  logic               hold, we, assert_o;
  logic [31:0]        waddr, data, iaddr_o;
  logic [NUM_IRQ-1:0] ack;

  clint_pri #(.NUM_IRQ(NUM_IRQ), .VECTORED_EN(1'b1)) dut (
    .clk(gclk), .rst(grst_n),
    .irq_i(irq), .irq_mask_i(mask), .global_int_en_i(mie),
    .inst_i(inst), .inst_addr_i(iaddr),
    .jump_flag_i(jflag), .jump_addr_i(jaddr),
    .csr_mtvec(mtvec), .csr_mepc(mepc), .csr_mstatus(mstatus),
    .hold_flag_o(hold), .we_o(we), .waddr_o(waddr), .data_o(data),
    .int_assert_o(assert_o), .int_addr_o(iaddr_o), .irq_ack_o(ack)
  );

  always #5 gclk = ~gclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the pending list of actions still to be performed.
  // 1 mepc write, 2 mstatus write, 3 mcause write, 4 trap redirect,
  // 5 mret mstatus write, 6 redirect to mepc, 0 nothing in progress.
  int          cur = 0;
  int          actq[$];
  logic [31:0] m_pc, m_cause;
  int          m_code, m_k;
  bit          m_async;
  logic        e_we, e_assert;
  logic [31:0] e_waddr, e_data, e_addr, e_ack;

  function automatic int m_event();
    if (inst == ECALL || inst == EBREAK) return 1;
    if (((irq & mask) != 0) && mie) return 2;
    if (inst == MRET) return 3;
    return 0;
  endfunction

  task automatic m_edge();
    int ev;
    if (cur == 0) begin
      ev = m_event();
      if (ev == 1) begin
        m_pc = iaddr; m_cause = (inst == ECALL) ? 32'd11 : 32'd3;
        m_async = 0; actq = '{2, 3, 4}; cur = 1;
      end else if (ev == 2) begin
        m_k = -1;
        for (int i = 0; i < NUM_IRQ; i++)
          if (m_k < 0 && irq[i] && mask[i]) m_k = i;
        m_code = 16 + m_k;
        m_pc = jflag ? jaddr : iaddr;
        m_cause = 32'h8000_0000 | m_code;
        m_async = 1; actq = '{2, 3, 4}; cur = 1;
      end else if (ev == 3) begin
        actq = '{6}; cur = 5;
      end
    end else begin
      cur = (actq.size() > 0) ? actq.pop_front() : 0;
    end
    e_we = 0; e_waddr = 0; e_data = 0; e_assert = 0; e_addr = 0; e_ack = 0;
    case (cur)
      1: begin
        e_we = 1; e_waddr = 32'h341; e_data = m_pc;
        if (m_async) e_ack = 32'd1 << m_k;
      end
      2: begin
        e_we = 1; e_waddr = 32'h300;
        e_data = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
      end
      3: begin e_we = 1; e_waddr = 32'h342; e_data = m_cause; end
      4: begin
        e_assert = 1;
        e_addr = mtvec & ~32'h3;
        if (mtvec % 4 == 1 && m_async) e_addr = e_addr + 32'(4 * m_code);
      end
      5: begin
        e_we = 1; e_waddr = 32'h300;
        e_data = (mstatus & ~32'h8) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
      end
      6: begin e_assert = 1; e_addr = mepc; end
      default: ;
    endcase
  endtask

  // One cycle: inputs already applied after a falling edge
  task automatic tick();
    #1;
    chk("hold", 32'(hold), 32'((cur != 0) || (m_event() != 0)));
    @(posedge gclk);
    m_edge();
    @(negedge gclk);
    chk("we", 32'(we), 32'(e_we));
    chk("waddr", waddr, e_waddr);
    chk("data", data, e_data);
    chk("assert", 32'(assert_o), 32'(e_assert));
    chk("addr", iaddr_o, e_addr);
    chk("ack", 32'(ack), e_ack);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hold"}, 32'(hold), 32'h0);
    chk({tag, "_we"}, 32'(we), 32'h0);
    chk({tag, "_waddr"}, waddr, 32'h0);
    chk({tag, "_data"}, data, 32'h0);
    chk({tag, "_assert"}, 32'(assert_o), 32'h0);
    chk({tag, "_addr"}, iaddr_o, 32'h0);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
  endtask

  task automatic set_idle();
    irq = '0; mask = '0; mie = 0; inst = NOP; iaddr = 32'h0;
    jflag = 0; jaddr = 32'h0; mtvec = 32'h0; mepc = 32'h0; mstatus = 32'h0;
  endtask

  task automatic drive_rand();
    int r;
    r = $urandom_range(0, 9);
    inst  = (r < 2) ? ECALL : (r == 2) ? EBREAK : (r == 3) ? MRET :
            (r == 4) ? $urandom : NOP;
    irq   = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0;
    mask  = NUM_IRQ'($urandom);
    mie   = ($urandom_range(0, 3) != 0);
    iaddr = $urandom & ~32'h3;
    jflag = $urandom_range(0, 1) == 1;
    jaddr = $urandom & ~32'h3;
    mtvec = $urandom;
    mepc  = $urandom;
    mstatus = $urandom;
  endtask

  initial begin
    set_idle();
    grst_n = 0;
    #1;
    chk_zero("reset");
    @(negedge gclk);
    grst_n = 1;

    // ECALL, vectored mtvec but synchronous -> direct target
    inst = ECALL; iaddr = 32'h100; mtvec = 32'h8000_0001; mstatus = 32'h8;
    irq = '0;
    tick(); chk("ecall_mepc", data, 32'h100);
    inst = NOP;
    tick(); chk("ecall_mstatus", data, 32'h80);
    tick(); chk("ecall_mcause", data, 32'd11);
    tick(); chk("ecall_target", iaddr_o, 32'h8000_0000);
    tick();

    // Vectored async with jump redirect
    irq = 8'h28; mask = 8'hFF; mie = 1; jflag = 1; jaddr = 32'h2000;
    iaddr = 32'h500;
    tick(); chk("vec_ack", 32'(ack), 32'h08); chk("vec_mepc", data, 32'h2000);
    irq = '0; jflag = 0;
    tick();
    tick(); chk("vec_mcause", data, 32'h8000_0013);
    tick(); chk("vec_target", iaddr_o, 32'h8000_004C);
    tick();

    // Masked line and MIE=0 stay pending without any activity
    irq = 8'h01; mask = 8'h00; mie = 1;
    repeat (3) tick();
    mask = 8'h01; mie = 0;
    repeat (2) tick();
    mie = 1;
    tick(); chk("unblock_waddr", waddr, 32'h341);
    irq = '0;
    repeat (4) tick();

    // MRET
    mstatus = 32'h80; mepc = 32'h344; inst = MRET;
    tick(); chk("mret_data", data, 32'h88);
    inst = NOP;
    tick(); chk("mret_target", iaddr_o, 32'h344);
    tick(); chk("mret_idle", 32'(assert_o), 32'h0);

    // EBREAK beats a concurrent enabled irq
    inst = EBREAK; irq = 8'h01; mask = 8'h01; mie = 1;
    tick();
    inst = NOP; irq = '0;
    tick();
    tick(); chk("ebreak_mcause", data, 32'd3);
    tick(); tick();

    // Reset during the mstatus write aborts the sequence
    inst = ECALL;
    tick();
    inst = NOP;
    tick();
    #2 grst_n = 0;
    #1 chk_zero("midreset");
    cur = 0; actq.delete();
    @(negedge gclk);
    grst_n = 1;
    repeat (3) tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive_rand();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
